// File: rtl/axi_test_sequencer.sv
// Run sequencer for the AXI4-Lite test master: pulses init_axi_txn, waits for txn_done, tallies pass/fail.
// Optional WAIT-state watchdog is built only when TXN_TIMEOUT_EN is defined.
module axi_test_sequencer #(
    parameter int unsigned RUN_CNT_W      = 16,
    parameter int unsigned INIT_PULSE_W   = 2,
    parameter int unsigned GAP_CYCLES     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                 m00_axi_aclk,
    input  logic                 m00_axi_aresetn,
    input  logic                 start,
    input  logic                 abort,
    input  logic [RUN_CNT_W-1:0] run_count,
    output logic                 init_axi_txn,
    input  logic                 txn_done,
    input  logic                 error,
    output logic                 busy,
    output logic                 done,
    output logic [RUN_CNT_W-1:0] pass_cnt,
    output logic [RUN_CNT_W-1:0] fail_cnt,
    output logic                 timeout
);

    localparam int unsigned PULSE_CW = (INIT_PULSE_W > 1) ? $clog2(INIT_PULSE_W) : 1;
    localparam int unsigned GAP_CW   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [PULSE_CW-1:0]  PULSE_LAST = PULSE_CW'(INIT_PULSE_W - 1);
    localparam logic [PULSE_CW-1:0]  PULSE_ONE  = PULSE_CW'(1'b1);
    localparam logic [PULSE_CW-1:0]  PULSE_ZERO = {PULSE_CW{1'b0}};
    localparam logic [GAP_CW-1:0]    GAP_LAST   = GAP_CW'(GAP_CYCLES - 1);
    localparam logic [GAP_CW-1:0]    GAP_ONE    = GAP_CW'(1'b1);
    localparam logic [GAP_CW-1:0]    GAP_ZERO   = {GAP_CW{1'b0}};
    localparam logic [RUN_CNT_W-1:0] CNT_ZERO   = {RUN_CNT_W{1'b0}};
    localparam logic [RUN_CNT_W-1:0] CNT_ONE    = RUN_CNT_W'(1'b1);
    localparam logic [RUN_CNT_W-1:0] CNT_MAX    = {RUN_CNT_W{1'b1}};

`ifdef TXN_TIMEOUT_EN
    localparam int unsigned WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1'b1);
    localparam logic [WD_W-1:0] WD_ZERO = {WD_W{1'b0}};
`endif

    if ((INIT_PULSE_W < 1) || (GAP_CYCLES < 1) || (TIMEOUT_CYCLES < 1)) begin : g_param_check
        $error("axi_test_sequencer: INIT_PULSE_W, GAP_CYCLES and TIMEOUT_CYCLES must be >= 1");
    end

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PULSE  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_GAP    = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [RUN_CNT_W-1:0] runs_left_q, runs_left_d;
    logic [PULSE_CW-1:0]  pulse_cnt_q, pulse_cnt_d;
    logic [GAP_CW-1:0]    gap_cnt_q, gap_cnt_d;
    logic [RUN_CNT_W-1:0] pass_q, pass_d;
    logic [RUN_CNT_W-1:0] fail_q, fail_d;
    logic                 txn_done_prev_q;
    logic                 init_q, init_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 completion_s;
`ifdef TXN_TIMEOUT_EN
    logic [WD_W-1:0]      wd_q, wd_d;
    logic                 timeout_q, timeout_d;
`endif

    function automatic logic [RUN_CNT_W-1:0] sat_inc(input logic [RUN_CNT_W-1:0] v);
        if (v == CNT_MAX) begin
            return v;
        end else begin
            return v + CNT_ONE;
        end
    endfunction

    // Only a rising txn_done counts, so a level left high from a previous run is ignored.
    assign completion_s = txn_done & ~txn_done_prev_q;

    // Next-state, counter and registered-output computation.
    always_comb begin
        state_d     = state_q;
        runs_left_d = runs_left_q;
        pulse_cnt_d = pulse_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        pass_d      = pass_q;
        fail_d      = fail_q;
`ifdef TXN_TIMEOUT_EN
        wd_d        = wd_q;
        timeout_d   = timeout_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    runs_left_d = run_count;
                    pass_d      = CNT_ZERO;
                    fail_d      = CNT_ZERO;
                    pulse_cnt_d = PULSE_ZERO;
`ifdef TXN_TIMEOUT_EN
                    timeout_d   = 1'b0;
`endif
                    state_d     = (run_count == CNT_ZERO) ? ST_FINISH : ST_PULSE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PULSE: begin
                if (abort) begin
                    state_d = ST_FINISH;
                end else if (pulse_cnt_q == PULSE_LAST) begin
                    state_d = ST_WAIT;
`ifdef TXN_TIMEOUT_EN
                    wd_d    = WD_ZERO;
`endif
                end else begin
                    pulse_cnt_d = pulse_cnt_q + PULSE_ONE;
                end
            end
            ST_WAIT: begin
                if (completion_s) begin
                    if (error) begin
                        fail_d = sat_inc(fail_q);
                    end else begin
                        pass_d = sat_inc(pass_q);
                    end
                    runs_left_d = runs_left_q - CNT_ONE;
                    if (abort || (runs_left_q == CNT_ONE)) begin
                        state_d = ST_FINISH;
                    end else begin
                        state_d   = ST_GAP;
                        gap_cnt_d = GAP_ZERO;
                    end
                end
`ifdef TXN_TIMEOUT_EN
                else if (wd_q == WD_LAST) begin
                    timeout_d = 1'b1;
                    fail_d    = sat_inc(fail_q);
                    state_d   = ST_FINISH;
                end
`endif
                else if (abort) begin
                    state_d = ST_FINISH;
                end else begin
                    state_d = ST_WAIT;
`ifdef TXN_TIMEOUT_EN
                    wd_d    = wd_q + WD_ONE;
`endif
                end
            end
            ST_GAP: begin
                if (abort) begin
                    state_d = ST_FINISH;
                end else if (gap_cnt_q == GAP_LAST) begin
                    state_d     = ST_PULSE;
                    pulse_cnt_d = PULSE_ZERO;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_ONE;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered versions of the upcoming state, so abort drops init on the same edge.
        init_d = (state_d == ST_PULSE);
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_FINISH);
    end

    // State, counters and output registers.
    always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
        if (!m00_axi_aresetn) begin
            state_q         <= ST_IDLE;
            runs_left_q     <= CNT_ZERO;
            pulse_cnt_q     <= PULSE_ZERO;
            gap_cnt_q       <= GAP_ZERO;
            pass_q          <= CNT_ZERO;
            fail_q          <= CNT_ZERO;
            txn_done_prev_q <= 1'b0;
            init_q          <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            runs_left_q     <= runs_left_d;
            pulse_cnt_q     <= pulse_cnt_d;
            gap_cnt_q       <= gap_cnt_d;
            pass_q          <= pass_d;
            fail_q          <= fail_d;
            txn_done_prev_q <= txn_done;
            init_q          <= init_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
        end
    end

`ifdef TXN_TIMEOUT_EN
    // Watchdog counter and sticky timeout flag.
    always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
        if (!m00_axi_aresetn) begin
            wd_q      <= WD_ZERO;
            timeout_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign init_axi_txn = init_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign pass_cnt     = pass_q;
    assign fail_cnt     = fail_q;

endmodule
